seq_sat_adder: RTL and testbench

Multi-cycle signed saturating 16-bit adder/subtractor. Processes the operands one CLA slice per clock, least significant slice first, using slices built from the team's 1-bit P/G full adders.
Sits between decode/operand fetch and writeback. Produces the saturated result plus Z/V/N flags for the flag register.
Uses a start/done handshake so the control unit can stall while it is busy.

---
 rtl/seq_sat_adder_pkg.sv | 18 +
 rtl/full_adder_1bit.sv | 16 +
 rtl/seq_sat_adder_cla_slice.sv | 49 ++++
 rtl/seq_sat_adder.sv | 156 +++++++++++++++
 tb/tb_seq_sat_adder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_sat_adder_pkg.sv
// Shared definitions for the sequential saturating adder: FSM state
// encoding, default geometry and the saturation limits for that geometry.
package seq_sat_adder_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Signed limits at the default width.
  localparam logic [WIDTH_DEF-1:0] SAT_POS = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic [WIDTH_DEF-1:0] SAT_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/full_adder_1bit.sv
// 1-bit full adder that also exports propagate/generate so that a
// lookahead network can form the carries instead of rippling them.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic p,
  output logic g
);

  assign p   = a ^ b;
  assign g   = a & b;
  assign sum = p ^ cin;

endmodule

// File: rtl/seq_sat_adder_cla_slice.sv
// SLICE-bit carry-lookahead slice. Every carry is built directly from the
// P/G terms and cin, so no carry depends on a lower carry signal.
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE:0]   w_c;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
      full_adder_1bit u_fa (
        .a   (a[gi]),
        .b   (b[gi]),
        .cin (w_c[gi]),
        .sum (sum[gi]),
        .p   (w_p[gi]),
        .g   (w_g[gi])
      );
    end
  endgenerate

  // Expanded lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    logic v_prod;
    w_c    = '0;
    v_prod = 1'b0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      w_c[i+1] = w_g[i];
      v_prod   = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (v_prod & w_g[j]);
        v_prod   = v_prod & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (v_prod & cin);
    end
  end

  assign cout = w_c[SLICE];

endmodule

// File: rtl/seq_sat_adder.sv
// Multi-cycle signed saturating adder/subtractor. One lookahead slice is
// evaluated per clock, LSB slice first; result and Z/V/N flags are
// registered on the last slice and held until the next completion.
module seq_sat_adder
  import seq_sat_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovfl,
  output logic             neg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] L_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int MSB = WIDTH - 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // B already inverted for subtraction
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovfl;
  logic             r_neg;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_ovfl;
  logic [WIDTH-1:0] w_sat;

  assign w_last    = (r_cnt == LAST_CNT);
  assign w_a_slice = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_slice = r_b[r_cnt*SLICE +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // Partial sum with the current slice merged in; complete on the last slice.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[r_cnt*SLICE +: SLICE] = w_slice_sum;
  end

  // Overflow when operands share a sign the raw sum does not; clamp toward A's sign.
  always_comb begin
    w_ovfl = (r_a[MSB] == r_b[MSB]) && (w_sum_next[MSB] != r_a[MSB]);
    w_sat  = w_sum_next;
    if (w_ovfl) begin
      w_sat = r_a[MSB] ? L_SAT_NEG : L_SAT_POS;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is honoured only in IDLE or DONE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_accept     = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_state_next = RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, slice-by-slice accumulation and result/flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovfl   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_sat;
        r_zero   <= (w_sat == '0);
        r_ovfl   <= w_ovfl;
        r_neg    <= w_sat[MSB];
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign zero   = r_zero;
  assign ovfl   = r_ovfl;
  assign neg    = r_neg;

endmodule

// File: tb/tb_seq_sat_adder.sv
// Bench for seq_sat_adder: directed corner cases plus random operations.
// Expected results come from plain integer arithmetic with clamping and are
// queued at the accepting edge; a monitor pops and compares on each done.
module tb_seq_sat_adder;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        v;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic        ovfl;
  logic        neg;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  seq_sat_adder dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .ovfl   (ovfl),
    .neg    (neg)
  );

  always #5 clk = ~clk;

  // Reference: exact signed arithmetic, then clamp to the 16-bit range.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    int   sx;
    int   sy;
    int   r;
    exp_t e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = s ? (sx - sy) : (sx + sy);
    e  = '0;
    if (r > 32767) begin
      e.r = 16'h7FFF;
      e.v = 1'b1;
    end else if (r < -32768) begin
      e.r = 16'h8000;
      e.v = 1'b1;
    end else begin
      e.r = r[15:0];
      e.v = 1'b0;
    end
    e.z = (e.r == 16'h0000);
    e.n = e.r[15];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("op: result=%04h z=%0b v=%0b n=%0b (expect %04h z=%0b v=%0b n=%0b)",
                 result, zero, ovfl, neg, e.r, e.z, e.v, e.n);
        chk("result", 32'(result), 32'(e.r));
        chk("zero", 32'(zero), 32'(e.z));
        chk("ovfl", 32'(ovfl), 32'(e.v));
        chk("neg", 32'(neg), 32'(e.n));
      end
    end
  end

  // Issue one operation and check busy/done timing. With hold_start, start
  // stays high through RUN while the operands are scrambled (must be ignored).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                        input logic hold_start);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);
    e = model(ta, tb_v, ts);
    exp_q.push_back(e);
    last_exp = e;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      if (!hold_start || k >= 4) start = 1'b0;
      chk($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= 4));
      chk($sformatf("done_c%0d", k), 32'(done), 32'(k == 5));
    end
  endtask

  initial begin
    logic [15:0] va;
    logic [15:0] vb;
    int          done_seen;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({zero, ovfl, neg}), 32'd0);
    rst = 1'b0;

    // Directed corner cases.
    run_op(16'h1234, 16'h0101, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    run_op(16'h0000, 16'h8000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 1'b0);
    run_op(16'h0003, 16'h0007, 1'b1, 1'b0);

    // Result held in IDLE.
    repeat (3) @(negedge clk);
    chk("hold_result", 32'(result), 32'(last_exp.r));
    chk("hold_done", 32'(done), 32'd0);

    // start held through RUN with new operands, then back-to-back accept in DONE.
    @(negedge clk);
    a = 16'h1234; b = 16'h0101; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(16'h1234, 16'h0101, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
      end
      if (k == 5) exp_q.push_back(model(16'hAAAA, 16'h5555, 1'b0));
      if (k == 6) start = 1'b0;
      chk($sformatf("b2b_busy_c%0d", k), 32'(busy), 32'(k != 5 && k != 10));
      chk($sformatf("b2b_done_c%0d", k), 32'(done), 32'(k == 5 || k == 10));
    end

    // Reset in RUN cycle 2 aborts the operation.
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(16'h0100, 16'h0200, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({zero, ovfl, neg}), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_op(16'h4000, 16'h3000, 1'b0, 1'b0);

    // Random operations, biased toward the signed extremes.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       va = 16'h7FFF;
        1:       va = 16'h8000;
        default: va = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       vb = 16'h8000;
        1:       vb = 16'h0001;
        default: vb = 16'($urandom);
      endcase
      run_op(va, vb, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
